// File: rtl/clock_pkg.sv
// Shared BCD limits, field positions and helpers for the HH:MM:SS clock.
package clock_pkg;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [7:0] HOUR_MAX     = 8'h23;
    localparam logic [7:0] NOON         = 8'h12;

    localparam int S0_LO = 0;
    localparam int S1_LO = 4;
    localparam int M0_LO = 8;
    localparam int M1_LO = 12;
    localparam int H0_LO = 16;
    localparam int H1_LO = 20;

    // Value a digit takes after one increment with wrap at max.
    function automatic logic [3:0] digit_next(input logic [3:0] q, input logic [3:0] max);
        return (q == max) ? 4'd0 : q + 4'd1;
    endfunction

    // BCD hour pair successor, 23 wraps to 00.
    function automatic logic [7:0] hour_next(input logic [7:0] h);
        logic [7:0] r;
        if (h == HOUR_MAX)
            r = 8'h00;
        else if (h[3:0] == DIGIT_MAX)
            r = {h[7:4] + 4'd1, 4'd0};
        else
            r = {h[7:4], h[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic bcd_valid_time(input logic [23:0] t);
        logic ok;
        ok = (t[S0_LO +: 4] <= DIGIT_MAX) && (t[S1_LO +: 4] <= SEC_TENS_MAX) &&
             (t[M0_LO +: 4] <= DIGIT_MAX) && (t[M1_LO +: 4] <= MIN_TENS_MAX) &&
             (t[H0_LO +: 4] <= DIGIT_MAX) && (t[H0_LO +: 8] <= HOUR_MAX);
        return ok;
    endfunction
endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MAX with load and carry-out.
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] q,
    output logic       carry
);
    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = load_val;
        else if (inc)
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= 4'd0;
        else     q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = inc & (q_q == MAX);
endmodule

// File: rtl/bcd_rtc_clock.sv
// BCD real-time clock: prescaled seconds, validated load, alarm, 12/24h display.
module bcd_rtc_clock
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        set_en,
    input  logic [23:0] set_time,
    input  logic [23:0] alarm_time,
    input  logic        alarm_en,
    input  logic        mode_12h,
    output logic [23:0] time_out,
    output logic        pm,
    output logic        sec_tick,
    output logic        day_tick,
    output logic        alarm,
    output logic        set_err
);
    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [7:0]            hour_q, hour_d, hour_adv;
    logic                  sec_tick_q, sec_tick_d;
    logic                  day_tick_q, day_tick_d;
    logic                  alarm_q, alarm_d;
    logic                  set_err_q, set_err_d;

    logic        tick, adv, load_ok, load_bad;
    logic [3:0]  s0, s1, m0, m1;
    logic        s0_c, s1_c, m0_c, m1_c;
    logic [23:0] time_cur, time_nxt;
    logic [7:0]  disp_hour;

    assign tick     = enable && (presc_q == PRESC_LAST);
    assign load_ok  = set_en && bcd_valid_time(set_time);
    assign load_bad = set_en && !bcd_valid_time(set_time);
    // A valid load swallows a coincident tick entirely.
    assign adv      = tick && !load_ok;

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_s0 (
        .clk(clk), .rst(rst), .inc(adv), .load(load_ok),
        .load_val(set_time[S0_LO +: 4]), .q(s0), .carry(s0_c));
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_s1 (
        .clk(clk), .rst(rst), .inc(s0_c), .load(load_ok),
        .load_val(set_time[S1_LO +: 4]), .q(s1), .carry(s1_c));
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_m0 (
        .clk(clk), .rst(rst), .inc(s1_c), .load(load_ok),
        .load_val(set_time[M0_LO +: 4]), .q(m0), .carry(m0_c));
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_m1 (
        .clk(clk), .rst(rst), .inc(m0_c), .load(load_ok),
        .load_val(set_time[M1_LO +: 4]), .q(m1), .carry(m1_c));

    assign time_cur = {hour_q, m1, m0, s1, s0};
    assign hour_adv = m1_c ? hour_next(hour_q) : hour_q;

    // Mirror of what the counters will hold after this edge, for the alarm compare.
    always_comb begin
        time_nxt = time_cur;
        if (adv) begin
            time_nxt[S0_LO +: 4] = digit_next(s0, DIGIT_MAX);
            if (s0_c) time_nxt[S1_LO +: 4] = digit_next(s1, SEC_TENS_MAX);
            if (s1_c) time_nxt[M0_LO +: 4] = digit_next(m0, DIGIT_MAX);
            if (m0_c) time_nxt[M1_LO +: 4] = digit_next(m1, MIN_TENS_MAX);
            time_nxt[H0_LO +: 8] = hour_adv;
        end
    end

    always_comb begin
        presc_d    = presc_q;
        hour_d     = hour_adv;
        sec_tick_d = adv;
        day_tick_d = adv && (time_cur == 24'h235959);
        alarm_d    = adv && alarm_en && (time_nxt == alarm_time);
        set_err_d  = load_bad;
        if (load_ok) begin
            presc_d = '0;
            hour_d  = set_time[H0_LO +: 8];
        end else if (enable) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            hour_q     <= 8'h00;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            alarm_q    <= alarm_d;
            set_err_q  <= set_err_d;
        end
    end

    // 12h view: 00 -> 12, 13..23 -> 01..11 with BCD borrow handled per tens digit.
    always_comb begin
        disp_hour = hour_q;
        if (mode_12h) begin
            if (hour_q == 8'h00)
                disp_hour = NOON;
            else if (hour_q > NOON) begin
                if (hour_q[7:4] == 4'd1)
                    disp_hour = {4'd0, hour_q[3:0] - 4'd2};
                else if (hour_q[3:0] < 4'd2)
                    disp_hour = {4'd0, hour_q[3:0] + 4'd8};
                else
                    disp_hour = {4'd1, hour_q[3:0] - 4'd2};
            end
        end
    end

    assign time_out = {disp_hour, m1, m0, s1, s0};
    assign pm       = (hour_q >= NOON);
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign alarm    = alarm_q;
    assign set_err  = set_err_q;
endmodule

// File: tb/tb_bcd_rtc_clock.sv
// Directed bench for bcd_rtc_clock with TICKS_PER_SEC=4.
module tb_bcd_rtc_clock;
    logic        clk = 1'b0;
    logic        rst, enable, set_en, alarm_en, mode_12h;
    logic [23:0] set_time, alarm_time, time_out;
    logic        pm, sec_tick, day_tick, alarm, set_err;
    int          total = 0;
    int          bad   = 0;
    int          pulses;

    bcd_rtc_clock #(.TICKS_PER_SEC(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .set_en(set_en),
        .set_time(set_time), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .mode_12h(mode_12h), .time_out(time_out), .pm(pm),
        .sec_tick(sec_tick), .day_tick(day_tick), .alarm(alarm), .set_err(set_err));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [23:0] t);
        set_time = t;
        set_en   = 1'b1;
        step(1);
        set_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; set_en = 1'b0; set_time = '0;
        alarm_time = 24'h999999; alarm_en = 1'b0; mode_12h = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_time24", time_out, 24'h000000);
        chk("rst_pm", {23'd0, pm}, 24'd0);
        chk("rst_strobes", {20'd0, sec_tick, day_tick, alarm, set_err}, 24'd0);
        mode_12h = 1'b1; #1;
        chk("rst_time12", time_out, 24'h120000);
        chk("rst_pm12", {23'd0, pm}, 24'd0);
        mode_12h = 1'b0;

        // 40 cycles of counting; tick lands on every 4th edge.
        enable = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk($sformatf("run_sec_tick_%0d", k), {23'd0, sec_tick}, {23'd0, (k % 4) == 0});
        end
        chk("run_time", time_out, 24'h000010);

        // Day rollover.
        load(24'h235958);
        chk("load_235958", time_out, 24'h235958);
        chk("load_no_tick", {23'd0, sec_tick}, 24'd0);
        step(4);
        chk("t_235959", time_out, 24'h235959);
        chk("t_235959_tick", {22'd0, sec_tick, day_tick}, 24'd2);
        step(4);
        chk("t_rollover", time_out, 24'h000000);
        chk("t_rollover_ticks", {22'd0, sec_tick, day_tick}, 24'd3);
        step(1);
        chk("day_tick_pulse", {22'd0, sec_tick, day_tick}, 24'd0);

        // 12-hour display with time frozen.
        enable = 1'b0; mode_12h = 1'b1;
        load(24'h000000); chk("h12_000000", {pm, time_out}, {1'b0, 24'h120000});
        load(24'h115959); chk("h12_115959", {pm, time_out}, {1'b0, 24'h115959});
        load(24'h120000); chk("h12_120000", {pm, time_out}, {1'b1, 24'h120000});
        load(24'h200000); chk("h12_200000", {pm, time_out}, {1'b1, 24'h080000});
        load(24'h235959); chk("h12_235959", {pm, time_out}, {1'b1, 24'h115959});
        load(24'h134512); chk("h12_134512", {pm, time_out}, {1'b1, 24'h014512});
        mode_12h = 1'b0; #1;
        chk("h24_134512", {pm, time_out}, {1'b1, 24'h134512});

        // Rejected loads.
        load(24'h246000);
        chk("bad_hour_err", {23'd0, set_err}, 24'd1);
        chk("bad_hour_time", time_out, 24'h134512);
        step(1);
        chk("bad_hour_err_end", {23'd0, set_err}, 24'd0);
        load(24'h125a00);
        chk("bad_digit_err", {23'd0, set_err}, 24'd1);
        chk("bad_digit_time", time_out, 24'h134512);
        step(1);
        chk("bad_digit_err_end", {23'd0, set_err}, 24'd0);

        // Load landing on a prescaler wrap.
        enable = 1'b1;
        load(24'h000000);
        step(3);
        load(24'h101010);
        chk("wrap_load_time", time_out, 24'h101010);
        chk("wrap_load_no_tick", {23'd0, sec_tick}, 24'd0);
        step(3);
        chk("wrap_hold_time", time_out, 24'h101010);
        step(1);
        chk("wrap_next_time", time_out, 24'h101011);
        chk("wrap_next_tick", {23'd0, sec_tick}, 24'd1);

        // Reset beats a coincident load.
        rst = 1'b1; set_en = 1'b1; set_time = 24'h050505;
        step(1);
        rst = 1'b0; set_en = 1'b0;
        chk("rst_over_load", time_out, 24'h000000);

        // Alarm at 00:00:05.
        alarm_time = 24'h000005; alarm_en = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (alarm) pulses++;
            chk($sformatf("alarm_%0d", k), {23'd0, alarm}, {23'd0, k == 20});
            if (k == 20) chk("alarm_time", time_out, 24'h000005);
        end
        chk("alarm_pulses", pulses[23:0], 24'd1);
        load(24'h000005);
        chk("reload_no_alarm", {23'd0, alarm}, 24'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("reload_quiet_%0d", k), {23'd0, alarm}, 24'd0);
        end
        chk("after_reload", time_out, 24'h000006);

        // Freeze mid-second; the partial second resumes afterwards.
        step(2);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk($sformatf("frozen_%0d", k), {sec_tick, time_out}, {1'b0, 24'h000006});
        end
        enable = 1'b1;
        step(1);
        chk("resume_1", {sec_tick, time_out}, {1'b0, 24'h000006});
        step(1);
        chk("resume_2", {sec_tick, time_out}, {1'b1, 24'h000007});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
